// File: rtl/bootram_pkg.sv
// Shared types and helpers for the boot RAM controller.
package bootram_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

  // One-hot lane enable for a single byte at the given byte offset within a word.
  function automatic logic [LANES-1:0] lane_sel(input logic [1:0] byte_off);
    lane_sel = 4'b0001 << byte_off;
  endfunction

endpackage

// File: rtl/bootram_rr_arb.sv
// Two-way round-robin arbiter between the CPU bus and the UART loader.
// rr_last remembers the most recent grantee so that on a tie the other
// requester wins; it moves on every accepted grant.
module bootram_rr_arb
  import bootram_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_cpu,
  input  logic   req_ld,
  input  logic   update,
  output logic   gnt_valid,
  output owner_t gnt
);

  owner_t rr_last;

  // Combinational grant: alternate on contention, otherwise serve whoever asks.
  always_comb begin
    gnt_valid = req_cpu | req_ld;
    if (req_cpu && req_ld) begin
      gnt = (rr_last == OWN_CPU) ? OWN_LD : OWN_CPU;
    end else if (req_ld) begin
      gnt = OWN_LD;
    end else begin
      gnt = OWN_CPU;
    end
  end

  // Remember the last grantee when the controller accepts a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= OWN_CPU;
    end else if (update) begin
      rr_last <= gnt;
    end else begin
      rr_last <= rr_last;
    end
  end

endmodule

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: sequences accesses to four 2Kx8 byte lanes and
// arbitrates between the CPU memory bus and the UART boot loader.
module bootram_ctrl
  import bootram_pkg::*;
#(
  parameter int RAM_AW = 11,
  parameter int CPU_AW = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_valid,
  input  logic [CPU_AW-1:0]   mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic                mem_ready,
  output logic [31:0]         mem_rdata,
  input  logic                ld_valid,
  input  logic [RAM_AW+1:0]   ld_addr,
  input  logic [7:0]          ld_data,
  output logic                ld_ready,
  input  logic                ld_excl,
  output logic [RAM_AW-1:0]   ram_ad,
  output logic [31:0]         ram_din,
  output logic [3:0]          ram_ce,
  output logic                ram_wre,
  output logic                ram_oce,
  input  logic [31:0]         ram_dout,
  output logic                busy
);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic              is_read, is_read_nxt;
  logic [RAM_AW-1:0] ram_ad_nxt;
  logic [31:0]       ram_din_nxt;
  logic [3:0]        ram_ce_nxt;
  logic              ram_wre_nxt;
  logic              mem_ready_nxt, ld_ready_nxt;
  logic [31:0]       mem_rdata_nxt;

  logic              req_cpu, req_ld, gnt_valid, arb_update;
  owner_t            gnt;

  // Address bits above the 8 KiB window and the CPU byte offset are ignored (aliasing).
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[CPU_AW-1:RAM_AW+2], mem_addr[1:0]};

  assign req_cpu    = mem_valid & ~ld_excl;
  assign req_ld     = ld_valid;
  assign arb_update = (state == IDLE) & gnt_valid;
  assign busy       = (state != IDLE);
  assign ram_oce    = 1'b1;

  bootram_rr_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_cpu   (req_cpu),
    .req_ld    (req_ld),
    .update    (arb_update),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  // Next-state and next-register values for the access sequencer.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    is_read_nxt   = is_read;
    ram_ad_nxt    = ram_ad;
    ram_din_nxt   = ram_din;
    ram_ce_nxt    = ram_ce;
    ram_wre_nxt   = ram_wre;
    mem_ready_nxt = 1'b0;
    ld_ready_nxt  = 1'b0;
    mem_rdata_nxt = mem_rdata;
    case (state)
      IDLE: begin
        ram_ce_nxt  = 4'h0;
        ram_wre_nxt = 1'b0;
        if (gnt_valid) begin
          state_nxt = ISSUE;
          owner_nxt = gnt;
          if (gnt == OWN_LD) begin
            ram_ad_nxt  = ld_addr[RAM_AW+1:2];
            ram_ce_nxt  = lane_sel(ld_addr[1:0]);
            ram_wre_nxt = 1'b1;
            ram_din_nxt = {LANES{ld_data}};
            is_read_nxt = 1'b0;
          end else begin
            ram_ad_nxt = mem_addr[RAM_AW+1:2];
            if (mem_wstrb == 4'b0000) begin
              ram_ce_nxt  = 4'hF;
              ram_wre_nxt = 1'b0;
              is_read_nxt = 1'b1;
            end else begin
              ram_ce_nxt  = mem_wstrb;
              ram_wre_nxt = 1'b1;
              ram_din_nxt = mem_wdata;
              is_read_nxt = 1'b0;
            end
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        // RAM samples at the end of this cycle; drop the strobes afterwards.
        ram_ce_nxt  = 4'h0;
        ram_wre_nxt = 1'b0;
        if (is_read) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = RESP;
          if (owner == OWN_LD) begin
            ld_ready_nxt = 1'b1;
          end else begin
            mem_ready_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        // Only CPU reads reach this state.
        mem_rdata_nxt = ram_dout;
        mem_ready_nxt = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        ram_ce_nxt  = 4'h0;
        ram_wre_nxt = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RAM register bank, ownership tracking, ready pulses and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_CPU;
      is_read   <= 1'b0;
      ram_ad    <= '0;
      ram_din   <= 32'h0;
      ram_ce    <= 4'h0;
      ram_wre   <= 1'b0;
      mem_ready <= 1'b0;
      ld_ready  <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      owner     <= owner_nxt;
      is_read   <= is_read_nxt;
      ram_ad    <= ram_ad_nxt;
      ram_din   <= ram_din_nxt;
      ram_ce    <= ram_ce_nxt;
      ram_wre   <= ram_wre_nxt;
      mem_ready <= mem_ready_nxt;
      ld_ready  <= ld_ready_nxt;
      mem_rdata <= mem_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_bootram_ctrl.sv
// Directed bench for bootram_ctrl with a behavioural 4x 2Kx8 RAM model.
module tb_bootram_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ld_valid = 1'b0;
  logic [12:0] ld_addr = 13'h0;
  logic [7:0]  ld_data = 8'h0;
  logic        ld_ready;
  logic        ld_excl = 1'b0;
  logic [10:0] ram_ad;
  logic [31:0] ram_din;
  logic [3:0]  ram_ce;
  logic        ram_wre;
  logic        ram_oce;
  logic [31:0] ram_dout;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [31:0] last_rdata = 32'h0;

  bootram_ctrl #(.RAM_AW(11), .CPU_AW(32)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_excl(ld_excl),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_ce(ram_ce), .ram_wre(ram_wre),
    .ram_oce(ram_oce), .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: four byte lanes, write-or-read per enabled lane, 1-cycle read latency.
  logic [7:0] mem [4][2048];
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (ram_ce[l]) begin
        if (ram_wre) mem[l][ram_ad] <= ram_din[8*l +: 8];
        else         ram_dout[8*l +: 8] <= mem[l][ram_ad];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  ld_data;
    logic [10:0] exp_ad;
    logic [3:0]  exp_ce;
    bit          exp_wre;
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  // Apply one transaction; entered and left at #1 after a rising edge with the DUT idle.
  task automatic run_vec(input int idx, input vec_t v);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    if (v.is_ld) begin
      ld_valid = 1'b1; ld_addr = v.addr[12:0]; ld_data = v.ld_data;
    end else begin
      mem_valid = 1'b1; mem_addr = v.addr; mem_wdata = v.wdata; mem_wstrb = v.wstrb;
    end
    while (!seen && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        chk($sformatf("v%0d_ad", idx), {21'h0, ram_ad}, {21'h0, v.exp_ad});
        chk($sformatf("v%0d_ce", idx), {28'h0, ram_ce}, {28'h0, v.exp_ce});
        chk($sformatf("v%0d_wre", idx), {31'h0, ram_wre}, {31'h0, v.exp_wre});
        if (v.exp_wre) chk($sformatf("v%0d_din", idx), ram_din, v.exp_din);
      end
      if (v.is_ld ? mem_ready : ld_ready)
        chk($sformatf("v%0d_wrong_ready", idx), 32'h1, 32'h0);
      if (v.is_ld ? ld_ready : mem_ready) seen = 1'b1;
    end
    chk($sformatf("v%0d_lat", idx), lat, v.exp_lat);
    mem_valid = 1'b0;
    ld_valid  = 1'b0;
    if (!v.is_ld && v.wstrb == 4'h0) last_rdata = v.exp_rdata;
    chk($sformatf("v%0d_rdata", idx), mem_rdata, last_rdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle", idx), {31'h0, busy}, 32'h0);
    chk($sformatf("v%0d_ready_clr", idx), {30'h0, mem_ready, ld_ready}, 32'h0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce"},    {28'h0, ram_ce}, 32'h0);
    chk({tag, "_wre"},   {31'h0, ram_wre}, 32'h0);
    chk({tag, "_ad"},    {21'h0, ram_ad}, 32'h0);
    chk({tag, "_din"},   ram_din, 32'h0);
    chk({tag, "_ready"}, {30'h0, mem_ready, ld_ready}, 32'h0);
    chk({tag, "_rdata"}, mem_rdata, 32'h0);
    chk({tag, "_busy"},  {31'h0, busy}, 32'h0);
    chk({tag, "_oce"},   {31'h0, ram_oce}, 32'h1);
  endtask

  initial begin
    int n_ld, n_cpu, cyc, k;
    bit exp_order[4];
    //          ld  addr           wdata         strb   ldd    ad      ce      wre  din           rdata         lat
    vecs[0]  = '{0, 32'h0000_0004, 32'h12345678, 4'hF, 8'h00, 11'h001, 4'hF, 1, 32'h12345678, 32'h0, 2};
    vecs[1]  = '{0, 32'h0000_0008, 32'h11223344, 4'hF, 8'h00, 11'h002, 4'hF, 1, 32'h11223344, 32'h0, 2};
    vecs[2]  = '{0, 32'h0000_07FC, 32'h01020304, 4'hF, 8'h00, 11'h1FF, 4'hF, 1, 32'h01020304, 32'h0, 2};
    vecs[3]  = '{0, 32'h0000_0004, 32'h0,        4'h0, 8'h00, 11'h001, 4'hF, 0, 32'h0, 32'h12345678, 3};
    vecs[4]  = '{0, 32'h0000_0008, 32'hAABBCCDD, 4'h4, 8'h00, 11'h002, 4'h4, 1, 32'hAABBCCDD, 32'h0, 2};
    vecs[5]  = '{0, 32'h0000_0008, 32'h0,        4'h0, 8'h00, 11'h002, 4'hF, 0, 32'h0, 32'h11BB3344, 3};
    vecs[6]  = '{1, 32'h0000_07FF, 32'h0,        4'h0, 8'h5A, 11'h1FF, 4'h8, 1, 32'h5A5A5A5A, 32'h0, 2};
    vecs[7]  = '{0, 32'h0000_07FC, 32'h0,        4'h0, 8'h00, 11'h1FF, 4'hF, 0, 32'h0, 32'h5A020304, 3};
    vecs[8]  = '{0, 32'h0000_2004, 32'h0,        4'h0, 8'h00, 11'h001, 4'hF, 0, 32'h0, 32'h12345678, 3};
    vecs[9]  = '{1, 32'h0000_0005, 32'h0,        4'h0, 8'hC3, 11'h001, 4'h2, 1, 32'hC3C3C3C3, 32'h0, 2};
    vecs[10] = '{0, 32'hFFFF_E004, 32'h0,        4'h0, 8'h00, 11'h001, 4'hF, 0, 32'h0, 32'h1234C378, 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle_busy", {31'h0, busy}, 32'h0);

    // Directed vector table
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Loader-exclusive mode with both requesters valid: only loader served
    @(negedge clk);
    ld_excl = 1'b1;
    mem_valid = 1'b1; mem_addr = 32'h4; mem_wstrb = 4'h0;
    ld_valid = 1'b1; ld_addr = 13'h7FF; ld_data = 8'h5A;
    n_ld = 0; n_cpu = 0; cyc = 0;
    while (n_ld < 2 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_ready) n_cpu++;
      if (ld_ready) n_ld++;
    end
    chk("excl_ld_grants", n_ld, 2);
    chk("excl_cpu_grants", n_cpu, 0);
    ld_excl = 1'b0;

    // Both held: CPU first (loader was last), then strict alternation
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    k = 0; cyc = 0;
    while (k < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_ready && ld_ready) begin
        chk("rr_double_ready", 32'h1, 32'h0);
        k++;
      end else if (mem_ready || ld_ready) begin
        chk($sformatf("rr_order%0d", k), {31'h0, ld_ready}, {31'h0, exp_order[k]});
        if (mem_ready) chk($sformatf("rr_rdata%0d", k), mem_rdata, 32'h1234C378);
        k++;
      end
    end
    chk("rr_grant_count", k, 4);
    mem_valid = 1'b0;
    ld_valid  = 1'b0;
    last_rdata = 32'h1234C378;
    @(posedge clk); #1;
    chk("rr_idle", {31'h0, busy}, 32'h0);

    // Reset while waiting for read data: transaction dropped silently
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h8; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    reset = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_ready", {30'h0, mem_ready, ld_ready}, 32'h0);
    last_rdata = 32'h0;
    run_vec(11, vecs[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
